mul_accum_stage: RTL



---
 rtl/mul_pipe_pkg.sv | 16 +
 rtl/mul_accum_stage_if.sv | 29 ++
 rtl/mul_acc_add.sv | 34 +++
 rtl/mul_accum_stage.sv | 118 +++++++++++
 4 files changed

// File: rtl/mul_pipe_pkg.sv
// Shared constants and types for the multiplier product accumulator.
package mul_pipe_pkg;

  localparam int PROD_W        = 64;
  localparam int DEF_ACC_W     = 72;
  localparam int DEF_BLOCK_LEN = 8;
  localparam int DEF_CNT_W     = 9;

  // Observable stage state, derived from registers rather than stored
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } acc_state_e;

endpackage

// File: rtl/mul_accum_stage_if.sv
// Product-in / block-result-out handshake bundle of mul_accum_stage.
interface mul_accum_stage_if
  import mul_pipe_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W,
  parameter int CNT_W = DEF_CNT_W
);
  logic              in_valid;
  logic [PROD_W-1:0] in_prod;
  logic              in_last;
  logic              in_ready;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic [CNT_W-1:0]  out_count;
  logic              out_ovf;
  acc_state_e        state;

  modport master (
    output in_valid, in_prod, in_last, flush, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf, state
  );

  modport slave (
    input  in_valid, in_prod, in_last, flush, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf, state
  );
endinterface

// File: rtl/mul_acc_add.sv
// Accumulator adder: acc plus zero-extended product.
// MUL_ACC_SAT_EN selects saturating add with carry-out as sat; otherwise wraps.
module mul_acc_add
  import mul_pipe_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  sum,
  output logic              sat
);

`ifdef MUL_ACC_SAT_EN
  logic [ACC_W:0] full_s;

  assign full_s = {1'b0, acc} + (ACC_W + 1)'(prod);

  // Clamp to all-ones when the add carries out
  always_comb begin
    if (full_s[ACC_W]) begin
      sum = {ACC_W{1'b1}};
      sat = 1'b1;
    end else begin
      sum = full_s[ACC_W-1:0];
      sat = 1'b0;
    end
  end
`else
  assign sum = acc + ACC_W'(prod);
  assign sat = 1'b0;
`endif

endmodule

// File: rtl/mul_accum_stage.sv
// Sums blocks of multiplier products and emits one held result per block.
// Optional saturation is enabled with `define MUL_ACC_SAT_EN.
module mul_accum_stage
  import mul_pipe_pkg::*;
#(
  parameter int ACC_W     = DEF_ACC_W,
  parameter int BLOCK_LEN = DEF_BLOCK_LEN,
  parameter int CNT_W     = DEF_CNT_W
) (
  input logic               clk,
  input logic               reset,
  mul_accum_stage_if.slave  bus
);

  logic [ACC_W-1:0] acc_r;
  logic [CNT_W-1:0] cnt_r;
  logic             ovf_r;
  logic             out_valid_r;
  logic [ACC_W-1:0] out_sum_r;
  logic [CNT_W-1:0] out_count_r;
  logic             out_ovf_r;

  logic             in_ready_s;
  logic             accept_s;
  logic             close_s;
  logic             flush_emit_s;
  logic             emit_s;
  logic [ACC_W-1:0] sum_s;
  logic             sat_s;
  logic [ACC_W-1:0] emit_sum_s;
  logic [CNT_W-1:0] emit_count_s;
  logic             emit_ovf_s;
  acc_state_e       state_s;

  mul_acc_add #(.ACC_W(ACC_W)) u_add (
    .acc  (acc_r),
    .prod (bus.in_prod),
    .sum  (sum_s),
    .sat  (sat_s)
  );

  assign in_ready_s   = !out_valid_r || bus.out_ready;
  assign accept_s     = bus.in_valid && in_ready_s;
  assign close_s      = accept_s && ((cnt_r == CNT_W'(BLOCK_LEN - 1)) || bus.in_last || bus.flush);
  // A beatless flush only closes a non-empty block while the result slot is free
  assign flush_emit_s = bus.flush && !accept_s && in_ready_s && (cnt_r != {CNT_W{1'b0}});
  assign emit_s       = close_s || flush_emit_s;

  // Select the values loaded into the result registers
  always_comb begin
    emit_sum_s   = acc_r;
    emit_count_s = cnt_r;
    emit_ovf_s   = ovf_r;
    if (close_s) begin
      emit_sum_s   = sum_s;
      emit_count_s = cnt_r + CNT_W'(1);
      emit_ovf_s   = ovf_r | sat_s;
    end else begin
      emit_sum_s   = acc_r;
      emit_count_s = cnt_r;
      emit_ovf_s   = ovf_r;
    end
  end

  // Running block accumulator, beat counter and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_r <= {ACC_W{1'b0}};
      cnt_r <= {CNT_W{1'b0}};
      ovf_r <= 1'b0;
    end else if (emit_s) begin
      acc_r <= {ACC_W{1'b0}};
      cnt_r <= {CNT_W{1'b0}};
      ovf_r <= 1'b0;
    end else if (accept_s) begin
      acc_r <= sum_s;
      cnt_r <= cnt_r + CNT_W'(1);
      ovf_r <= ovf_r | sat_s;
    end
  end

  // Held result; a new emit on the drain cycle keeps valid high
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      out_sum_r   <= {ACC_W{1'b0}};
      out_count_r <= {CNT_W{1'b0}};
      out_ovf_r   <= 1'b0;
    end else if (emit_s) begin
      out_valid_r <= 1'b1;
      out_sum_r   <= emit_sum_s;
      out_count_r <= emit_count_s;
      out_ovf_r   <= emit_ovf_s;
    end else if (out_valid_r && bus.out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  // Debug view of the stage state
  always_comb begin
    state_s = ST_IDLE;
    if (out_valid_r) begin
      state_s = ST_HOLD;
    end else if (cnt_r != {CNT_W{1'b0}}) begin
      state_s = ST_ACC;
    end else begin
      state_s = ST_IDLE;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_sum   = out_sum_r;
  assign bus.out_count = out_count_r;
  assign bus.out_ovf   = out_ovf_r;
  assign bus.state     = state_s;

endmodule
